// File: rtl/tds_readout_pkg.sv
// Shared constants for the TDS readout path (channel FIFOs, channel_data_4, readout_control).
// No logic, no latency.
// Holds no state, so there is no backpressure to describe.
package tds_readout_pkg;

    // Decoded TDS frame width.
    localparam int FRAME_W = 120;

    // Default per-channel FIFO depth in words (power of two).
    localparam int DEPTH   = 512;

    // Occupancy counter width; must hold the value DEPTH itself.
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    // Width of the saturating dropped-frame counter.
    localparam int DROP_W  = 16;

    // Saturating increment for the drop counter; holds at all-ones.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/tds_sdp_ram.sv
// Simple dual-port RAM, DEPTH x W, one write port and one registered read port (block RAM style).
// Latency: read data appears one clock after rd_en_i. A write is visible to reads issued on later cycles.
// No backpressure; the caller guarantees it never reads and writes the same live address.
module tds_sdp_ram #(
    parameter int W     = 120,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_dat_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_dat_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Storage write and registered read; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        if (rd_en_i) begin
            rd_dat_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/tds_channel_fifo.sv
// Per-channel first-word-fall-through frame buffer between a TDS lane decoder and readout_control.
// Latency: a write reaches channel_data two edges later; after a pop the next word follows with no bubble.
// The write side cannot be stalled: frames arriving while full are dropped and counted.
module tds_channel_fifo #(
    parameter int FRAME_W = tds_readout_pkg::FRAME_W,
    parameter int DEPTH   = tds_readout_pkg::DEPTH,
    parameter int CNT_W   = tds_readout_pkg::CNT_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [FRAME_W-1:0]                  frame_data,
    input  logic                                frame_valid,
    input  logic                                enable,
    input  logic                                channel_fifo_s_reset,
    input  logic                                data_tran_stop,
    input  logic                                channel_data_read,
    output logic [FRAME_W-1:0]                  channel_data,
    output logic [CNT_W-1:0]                    channel_data_counter,
    output logic                                channel_fifo_empty,
    output logic                                channel_fifo_full,
    output logic                                overflow,
    output logic [tds_readout_pkg::DROP_W-1:0]  drop_count,
    output logic                                data_valid_flag
);

    import tds_readout_pkg::*;

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Three places a word can live: RAM body, RAM read register (stage 1), output register.
    // cnt_q counts all of them; ram_cnt_q counts only words not yet read out of the RAM.
    logic [AW-1:0]      wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [CNT_W-1:0]   ram_cnt_q, ram_cnt_d;
    logic               s1_vld_q,  s1_vld_d;
    logic               out_vld_q, out_vld_d;
    logic [FRAME_W-1:0] out_dat_q, out_dat_d;
    logic               ovf_q,     ovf_d;
    logic [DROP_W-1:0]  drop_q,    drop_d;
    logic               dvf_q,     dvf_d;

    logic [FRAME_W-1:0] ram_rd_dat;
    logic               full;
    logic               wr_req;
    logic               wr_ok;
    logic               drop_ev;
    logic               pop;
    logic               out_load;
    logic               ram_rd_en;

    // Handshake decode; full is taken from the pre-edge counter, so a same-cycle pop never frees room.
    always_comb begin
        full      = (cnt_q == DEPTH_C);
        wr_req    = frame_valid & enable & ~data_tran_stop;
        wr_ok     = wr_req & ~full & ~channel_fifo_s_reset;
        drop_ev   = wr_req & full & ~channel_fifo_s_reset;
        pop       = channel_data_read & out_vld_q;
        out_load  = s1_vld_q & (~out_vld_q | pop);
        ram_rd_en = (ram_cnt_q != '0) & (~s1_vld_q | out_load) & ~channel_fifo_s_reset;
    end

    tds_sdp_ram #(
        .W     (FRAME_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_ok),
        .wr_addr_i (wr_ptr_q),
        .wr_dat_i  (frame_data),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (rd_ptr_q),
        .rd_dat_o  (ram_rd_dat)
    );

    // Next-state: pointers, occupancy, prefetch pipeline and drop accounting; soft reset wins over all.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        ram_cnt_d = ram_cnt_q;
        s1_vld_d  = s1_vld_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        ovf_d     = ovf_q;
        drop_d    = drop_q;
        dvf_d     = 1'b0;

        if (channel_fifo_s_reset) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cnt_d     = '0;
            ram_cnt_d = '0;
            s1_vld_d  = 1'b0;
            out_vld_d = 1'b0;
            out_dat_d = '0;
            ovf_d     = 1'b0;
            drop_d    = '0;
        end else begin
            // Pointers wrap naturally at DEPTH because AW = log2(DEPTH).
            wr_ptr_d  = wr_ptr_q + AW'(wr_ok);
            rd_ptr_d  = rd_ptr_q + AW'(ram_rd_en);
            cnt_d     = cnt_q + CNT_W'(wr_ok) - CNT_W'(pop);
            ram_cnt_d = ram_cnt_q + CNT_W'(wr_ok) - CNT_W'(ram_rd_en);

            // Stage 1 refills in the same cycle it hands its word to the output register.
            s1_vld_d  = ram_rd_en | (s1_vld_q & ~out_load);
            out_vld_d = out_load | (out_vld_q & ~pop);
            if (out_load) begin
                out_dat_d = ram_rd_dat;
            end

            if (drop_ev) begin
                ovf_d  = 1'b1;
                drop_d = sat_inc(drop_q);
            end
            dvf_d = wr_ok;
        end
    end

    // State registers; async reset returns every visible output to its idle value at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ram_cnt_q <= '0;
            s1_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
            dvf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            ram_cnt_q <= ram_cnt_d;
            s1_vld_q  <= s1_vld_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
            dvf_q     <= dvf_d;
        end
    end

    assign channel_data         = out_dat_q;
    assign channel_data_counter = cnt_q;
    assign channel_fifo_empty   = ~out_vld_q;
    assign channel_fifo_full    = full;
    assign overflow             = ovf_q;
    assign drop_count           = drop_q;
    assign data_valid_flag      = dvf_q;

endmodule

// File: tb/tb_tds_channel_fifo.sv
// Self-checking bench for tds_channel_fifo against a queue-based reference model.
// Model rule: a word is at the head once written two or more edges ago and all older words are popped.
// Read requests are honoured only while the model says a head word is available.
module tb_tds_channel_fifo;
    import tds_readout_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic [FRAME_W-1:0]  frame_data;
    logic                frame_valid;
    logic                enable;
    logic                channel_fifo_s_reset;
    logic                data_tran_stop;
    logic                channel_data_read;
    logic [FRAME_W-1:0]  channel_data;
    logic [CNT_W-1:0]    channel_data_counter;
    logic                channel_fifo_empty;
    logic                channel_fifo_full;
    logic                overflow;
    logic [DROP_W-1:0]   drop_count;
    logic                data_valid_flag;

    always #5 clk = ~clk;

    tds_channel_fifo dut (
        .clk                  (clk),
        .reset                (reset),
        .frame_data           (frame_data),
        .frame_valid          (frame_valid),
        .enable               (enable),
        .channel_fifo_s_reset (channel_fifo_s_reset),
        .data_tran_stop       (data_tran_stop),
        .channel_data_read    (channel_data_read),
        .channel_data         (channel_data),
        .channel_data_counter (channel_data_counter),
        .channel_fifo_empty   (channel_fifo_empty),
        .channel_fifo_full    (channel_fifo_full),
        .overflow             (overflow),
        .drop_count           (drop_count),
        .data_valid_flag      (data_valid_flag)
    );

    typedef struct {
        logic [FRAME_W-1:0] d;
        int                 t;
    } ent_t;

    ent_t mq[$];
    int   edge_n = 0;
    logic m_ovf  = 1'b0;
    int   m_drop = 0;
    logic m_dvf  = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    function automatic logic [FRAME_W-1:0] rnd_frame();
        return FRAME_W'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    function automatic logic exp_empty();
        return (mq.size() == 0) || (mq[0].t + 2 > edge_n);
    endfunction

    function automatic logic [FRAME_W-1:0] exp_head();
        return (mq.size() == 0) ? '0 : mq[0].d;
    endfunction

    // One clock of stimulus; inputs driven at the negedge, model updated at the posedge.
    task automatic tick(input logic fv, input logic [FRAME_W-1:0] fd, input logic en,
                        input logic stop, input logic rd, input logic srst);
        logic head_ok, full_m, wr_req;
        frame_valid          = fv;
        frame_data           = fd;
        enable               = en;
        data_tran_stop       = stop;
        channel_data_read    = rd;
        channel_fifo_s_reset = srst;
        head_ok = !exp_empty();
        full_m  = (mq.size() == DEPTH);
        wr_req  = fv && en && !stop;
        @(posedge clk);
        edge_n++;
        if (srst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
            m_dvf  = 1'b0;
        end else begin
            if (rd && head_ok) void'(mq.pop_front());
            if (wr_req && !full_m) mq.push_back('{fd, edge_n});
            if (wr_req && full_m) begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end
            m_dvf = wr_req && !full_m;
        end
        @(negedge clk);
        frame_valid          = 1'b0;
        channel_data_read    = 1'b0;
        channel_fifo_s_reset = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++; if (channel_fifo_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b exp 1", channel_fifo_empty); end
        n_vec++; if (channel_fifo_full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b exp 0", channel_fifo_full); end
        n_vec++; if (channel_data_counter !== '0) begin n_err++; $display("FAIL rst_cnt got %0d exp 0", channel_data_counter); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b exp 0", overflow); end
        n_vec++; if (drop_count !== '0) begin n_err++; $display("FAIL rst_drop got %0d exp 0", drop_count); end
        n_vec++; if (data_valid_flag !== 1'b0) begin n_err++; $display("FAIL rst_dvf got %b exp 0", data_valid_flag); end
        n_vec++; if (channel_data !== '0) begin n_err++; $display("FAIL rst_data got %h exp 0", channel_data); end
    endtask

    task automatic test_basic();
        logic [FRAME_W-1:0] v;
        tick(1'b1, FRAME_W'(1), 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (channel_fifo_empty !== 1'b1) begin n_err++; $display("FAIL basic_empty_e1 got %b exp 1", channel_fifo_empty); end
        n_vec++; if (data_valid_flag !== 1'b1) begin n_err++; $display("FAIL basic_dvf got %b exp 1", data_valid_flag); end
        tick(1'b1, FRAME_W'(2), 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (channel_fifo_empty !== 1'b1) begin n_err++; $display("FAIL basic_empty_e2 got %b exp 1", channel_fifo_empty); end
        tick(1'b1, FRAME_W'(3), 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (channel_fifo_empty !== 1'b0) begin n_err++; $display("FAIL basic_empty_e3 got %b exp 0", channel_fifo_empty); end
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (channel_data_counter !== CNT_W'(3)) begin n_err++; $display("FAIL basic_cnt got %0d exp 3", channel_data_counter); end
        n_vec++; if (data_valid_flag !== 1'b0) begin n_err++; $display("FAIL basic_dvf_idle got %b exp 0", data_valid_flag); end
        for (int k = 1; k <= 3; k++) begin
            v = FRAME_W'(k);
            n_vec++; if (channel_data !== v) begin n_err++; $display("FAIL basic_pop%0d got %h exp %h", k, channel_data, v); end
            tick(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        n_vec++; if (channel_fifo_empty !== 1'b1) begin n_err++; $display("FAIL basic_empty_end got %b exp 1", channel_fifo_empty); end
        n_vec++; if (channel_data_counter !== '0) begin n_err++; $display("FAIL basic_cnt_end got %0d exp 0", channel_data_counter); end
    endtask

    task automatic test_gated();
        int dvf_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'b1, rnd_frame(), (k < 10), (k < 10), 1'b0, 1'b0);
            if (data_valid_flag) dvf_seen++;
        end
        n_vec++; if (channel_data_counter !== '0) begin n_err++; $display("FAIL gated_cnt got %0d exp 0", channel_data_counter); end
        n_vec++; if (drop_count !== '0) begin n_err++; $display("FAIL gated_drop got %0d exp 0", drop_count); end
        n_vec++; if (dvf_seen != 0) begin n_err++; $display("FAIL gated_dvf got %0d pulses exp 0", dvf_seen); end
        n_vec++; if (channel_fifo_empty !== 1'b1) begin n_err++; $display("FAIL gated_empty got %b exp 1", channel_fifo_empty); end
    endtask

    task automatic test_fill_overflow();
        for (int k = 0; k < DEPTH + 5; k++) tick(1'b1, rnd_frame(), 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (channel_fifo_full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b exp 1", channel_fifo_full); end
        n_vec++; if (channel_data_counter !== CNT_W'(DEPTH)) begin n_err++; $display("FAIL fill_cnt got %0d exp %0d", channel_data_counter, DEPTH); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL fill_ovf got %b exp 1", overflow); end
        n_vec++; if (drop_count !== 16'd5) begin n_err++; $display("FAIL fill_drop got %0d exp 5", drop_count); end
        n_vec++; if (data_valid_flag !== 1'b0) begin n_err++; $display("FAIL fill_dvf got %b exp 0", data_valid_flag); end
        // Write and pop together while full: the write is still dropped.
        tick(1'b1, rnd_frame(), 1'b1, 1'b0, 1'b1, 1'b0);
        n_vec++; if (drop_count !== 16'd6) begin n_err++; $display("FAIL fullpop_drop got %0d exp 6", drop_count); end
        n_vec++; if (channel_data_counter !== CNT_W'(DEPTH - 1)) begin n_err++; $display("FAIL fullpop_cnt got %0d exp %0d", channel_data_counter, DEPTH - 1); end
        while (mq.size() > 0) begin
            n_vec++; if (channel_data !== exp_head() || channel_fifo_empty !== 1'b0) begin
                n_err++; $display("FAIL fill_readback got %h/empty=%b exp %h/empty=0", channel_data, channel_fifo_empty, exp_head());
            end
            tick(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        n_vec++; if (channel_fifo_empty !== 1'b1) begin n_err++; $display("FAIL fill_drained got %b exp 1", channel_fifo_empty); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 100; k++) tick(1'b1, rnd_frame(), 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 1000; k++) begin
            n_vec++; if (channel_data !== exp_head() || channel_fifo_empty !== 1'b0) begin
                n_err++; $display("FAIL b2b_data cyc %0d got %h/empty=%b exp %h/empty=0", k, channel_data, channel_fifo_empty, exp_head());
            end
            tick(1'b1, rnd_frame(), 1'b1, 1'b0, 1'b1, 1'b0);
            n_vec++; if (channel_data_counter !== CNT_W'(100)) begin n_err++; $display("FAIL b2b_cnt cyc %0d got %0d exp 100", k, channel_data_counter); end
        end
    endtask

    task automatic test_soft_reset();
        // Enter holding 100 words from the back-to-back run; drain to 20.
        for (int k = 0; k < 80; k++) tick(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        n_vec++; if (channel_data_counter !== CNT_W'(20)) begin n_err++; $display("FAIL srst_pre_cnt got %0d exp 20", channel_data_counter); end
        tick(1'b1, rnd_frame(), 1'b1, 1'b0, 1'b1, 1'b1);
        n_vec++; if (channel_data_counter !== '0) begin n_err++; $display("FAIL srst_cnt got %0d exp 0", channel_data_counter); end
        n_vec++; if (channel_fifo_empty !== 1'b1) begin n_err++; $display("FAIL srst_empty got %b exp 1", channel_fifo_empty); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL srst_ovf got %b exp 0", overflow); end
        n_vec++; if (drop_count !== '0) begin n_err++; $display("FAIL srst_drop got %0d exp 0", drop_count); end
        n_vec++; if (channel_data !== '0) begin n_err++; $display("FAIL srst_data got %h exp 0", channel_data); end
        repeat (3) tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (channel_data_counter !== '0 || channel_fifo_empty !== 1'b1) begin
            n_err++; $display("FAIL srst_write_lost got cnt=%0d empty=%b exp cnt=0 empty=1", channel_data_counter, channel_fifo_empty);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 50; k++) tick(1'b1, rnd_frame(), 1'b1, 1'b0, (k > 10), 1'b0);
        frame_valid = 1'b1;
        frame_data  = rnd_frame();
        reset = 1'b1;
        #1;
        n_vec++; if (channel_fifo_empty !== 1'b1 || channel_fifo_full !== 1'b0) begin
            n_err++; $display("FAIL arst_flags got empty=%b full=%b exp 1/0", channel_fifo_empty, channel_fifo_full);
        end
        n_vec++; if (channel_data_counter !== '0 || overflow !== 1'b0 || drop_count !== '0) begin
            n_err++; $display("FAIL arst_counts got cnt=%0d ovf=%b drop=%0d exp 0/0/0", channel_data_counter, overflow, drop_count);
        end
        n_vec++; if (channel_data !== '0 || data_valid_flag !== 1'b0) begin
            n_err++; $display("FAIL arst_data got %h dvf=%b exp 0/0", channel_data, data_valid_flag);
        end
        #1;
        reset       = 1'b0;
        frame_valid = 1'b0;
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        m_dvf  = 1'b0;
        for (int k = 0; k < 3; k++) tick(1'b1, rnd_frame(), 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (channel_data_counter !== CNT_W'(3)) begin n_err++; $display("FAIL arst_post_cnt got %0d exp 3", channel_data_counter); end
        while (mq.size() > 0) begin
            n_vec++; if (channel_data !== exp_head()) begin n_err++; $display("FAIL arst_post_data got %h exp %h", channel_data, exp_head()); end
            tick(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_random();
        int wp, rp;
        logic srst;
        for (int k = 0; k < 3000; k++) begin
            wp   = (k < 1500) ? 9 : 3;
            rp   = (k < 1500) ? 3 : 8;
            srst = (k >= 1500) && ($urandom_range(0, 499) == 0);
            tick($urandom_range(0, 9) < wp, rnd_frame(), $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) < rp, srst);
            n_vec++; if (channel_data_counter !== CNT_W'(mq.size()) || channel_fifo_full !== (mq.size() == DEPTH)) begin
                n_err++; $display("FAIL rnd_cnt cyc %0d got %0d/full=%b exp %0d", k, channel_data_counter, channel_fifo_full, mq.size());
            end
            n_vec++; if (channel_fifo_empty !== exp_empty()) begin
                n_err++; $display("FAIL rnd_empty cyc %0d got %b exp %b", k, channel_fifo_empty, exp_empty());
            end
            if (!exp_empty()) begin
                n_vec++; if (channel_data !== exp_head()) begin n_err++; $display("FAIL rnd_data cyc %0d got %h exp %h", k, channel_data, exp_head()); end
            end
            n_vec++; if (overflow !== m_ovf || drop_count !== DROP_W'(m_drop) || data_valid_flag !== m_dvf) begin
                n_err++; $display("FAIL rnd_acct cyc %0d got ovf=%b drop=%0d dvf=%b exp %b/%0d/%b",
                                  k, overflow, drop_count, data_valid_flag, m_ovf, m_drop, m_dvf);
            end
        end
    endtask

    initial begin
        reset                = 1'b1;
        frame_data           = '0;
        frame_valid          = 1'b0;
        enable               = 1'b0;
        channel_fifo_s_reset = 1'b0;
        data_tran_stop       = 1'b0;
        channel_data_read    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_basic();
        test_gated();
        test_fill_overflow();
        test_back_to_back();
        test_soft_reset();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
